// File: rtl/checkpoint_ctrl_if.sv
// Rename/resolve handshake between decode, branch units and the checkpoint controller.
// The master modport is the decode/resolve side, and the slave modport is the controller.
interface checkpoint_ctrl_if #(
    parameter int CP_NUM        = 4,
    parameter int CP_INDEX_SIZE = 2,
    parameter int WAYS          = 4
);
    logic                     pause;
    logic [WAYS-1:0]          rename_valid;
    logic [WAYS-1:0]          rename_is_br;
    logic                     rename_ready;
    logic                     check;
    logic [CP_INDEX_SIZE-1:0] check_index;
    logic                     resolve_valid;
    logic [CP_INDEX_SIZE-1:0] resolve_tag;
    logic                     resolve_mispredict;
    logic                     request;
    logic [CP_INDEX_SIZE-1:0] request_index;
    logic                     recover;
    logic [CP_NUM-1:0]        flush_mask;
    logic [CP_INDEX_SIZE:0]   cp_free_count;

    modport master (
        output pause, rename_valid, rename_is_br,
        output resolve_valid, resolve_tag, resolve_mispredict,
        input  rename_ready, check, check_index,
        input  request, request_index, recover, flush_mask, cp_free_count
    );

    modport slave (
        input  pause, rename_valid, rename_is_br,
        input  resolve_valid, resolve_tag, resolve_mispredict,
        output rename_ready, check, check_index,
        output request, request_index, recover, flush_mask, cp_free_count
    );
endinterface

// File: rtl/checkpoint_ctrl.sv
// Rename-stage checkpoint controller: allocates RAT checkpoint slots in ring order,
// frees them on resolution and sequences mispredict recovery.
module checkpoint_ctrl #(
    parameter int CP_NUM        = 4,
    parameter int CP_INDEX_SIZE = 2,
    parameter int WAYS          = 4
) (
    input logic              clock,
    input logic              reset,
    checkpoint_ctrl_if.slave bus
);
    typedef enum logic [1:0] {NORMAL, RESTORE, RESUME} state_t;

    state_t                   state, state_next;
    logic [CP_NUM-1:0]        valid, valid_next;
    logic [CP_INDEX_SIZE-1:0] tail, tail_next;
    logic [CP_INDEX_SIZE-1:0] rec_tag, rec_tag_next;

    logic [WAYS-1:0]          br_bits;
    logic                     br_present;
    logic                     mis_hit;
    logic                     cor_hit;
    logic [CP_NUM-1:0]        killed;
    logic [CP_INDEX_SIZE-1:0] rec_age;
    logic [CP_INDEX_SIZE:0]   used;

    // Distance from the youngest allocated slot (tail-1); larger means older.
    function automatic logic [CP_INDEX_SIZE-1:0] age_of(
        input logic [CP_INDEX_SIZE-1:0] t_tail,
        input logic [CP_INDEX_SIZE-1:0] t
    );
        return t_tail - CP_INDEX_SIZE'(1) - t;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= NORMAL;
            valid   <= '0;
            tail    <= '0;
            rec_tag <= '0;
        end else begin
            state   <= state_next;
            valid   <= valid_next;
            tail    <= tail_next;
            rec_tag <= rec_tag_next;
        end
    end

    always_comb begin
        state_next        = state;
        valid_next        = valid;
        tail_next         = tail;
        rec_tag_next      = rec_tag;
        bus.rename_ready  = 1'b0;
        bus.check         = 1'b0;
        bus.check_index   = tail;
        bus.request       = 1'b0;
        bus.recover       = 1'b0;
        bus.request_index = '0;
        bus.flush_mask    = '0;

        br_bits    = bus.rename_valid & bus.rename_is_br;
        br_present = |br_bits;
        mis_hit    = bus.resolve_valid &  bus.resolve_mispredict & valid[bus.resolve_tag];
        cor_hit    = bus.resolve_valid & ~bus.resolve_mispredict & valid[bus.resolve_tag];

        rec_age = age_of(tail, rec_tag);
        for (int unsigned i = 0; i < CP_NUM; i++) begin
            killed[i] = (CP_INDEX_SIZE'(i) == rec_tag) ||
                        (valid[i] && (age_of(tail, CP_INDEX_SIZE'(i)) < rec_age));
        end

        case (state)
            RESTORE: begin
                bus.request       = 1'b1;
                bus.recover       = 1'b1;
                bus.request_index = rec_tag;
                bus.flush_mask    = killed;
                // A valid tag outside the killed set is older: retarget and replay RESTORE
                // before touching valid/tail so the next killed set is computed from intact state.
                if (mis_hit && !killed[bus.resolve_tag]) begin
                    rec_tag_next = bus.resolve_tag;
                end else begin
                    valid_next = valid & ~killed;
                    tail_next  = rec_tag;
                    state_next = RESUME;
                end
                if (cor_hit && !killed[bus.resolve_tag]) begin
                    valid_next[bus.resolve_tag] = 1'b0;
                end
            end
            default: begin
                bus.rename_ready = (state == NORMAL) && !bus.pause && !mis_hit &&
                                   (!br_present || !valid[tail]);
                bus.check        = bus.rename_ready && br_present;
                if (bus.check) begin
                    valid_next[tail] = 1'b1;
                    tail_next        = tail + CP_INDEX_SIZE'(1);
                end
                if (cor_hit) begin
                    valid_next[bus.resolve_tag] = 1'b0;
                end
                if (mis_hit) begin
                    rec_tag_next = bus.resolve_tag;
                    state_next   = RESTORE;
                end else if (state == RESUME) begin
                    state_next = NORMAL;
                end
            end
        endcase
    end

    always_comb begin
        used = '0;
        for (int unsigned i = 0; i < CP_NUM; i++) begin
            used = used + (CP_INDEX_SIZE + 1)'(valid[i]);
        end
        bus.cp_free_count = (CP_INDEX_SIZE + 1)'(CP_NUM) - used;
    end
endmodule
